// File: rtl/pulse_gen_pkg.sv
// Shared constants for the trigger/test pulse generator: clock rate,
// default timing parameters and the phase counter width.
package pulse_gen_pkg;

  localparam int unsigned CLK_HZ         = 111_111_111;
  localparam int unsigned CNT_W          = 32;

  localparam int unsigned DEF_PERIOD_CYC = 111_111;
  localparam int unsigned DEF_TR_WIDTH   = 111;
  localparam int unsigned DEF_TP_DELAY   = 222;
  localparam int unsigned DEF_TP_WIDTH   = 56;

endpackage : pulse_gen_pkg

// File: rtl/pulse_gen_timer32.sv
// Free-running 32-bit phase counter with synchronous clear, run enable
// and a terminal-count strobe; wraps from PERIOD_CYC-1 straight to 0.
module timer32
  import pulse_gen_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC
) (
  input  logic             clk,
  input  logic             rst,    // asynchronous, active-low
  input  logic             clr,
  input  logic             ena,
  output logic [CNT_W-1:0] cnt,
  output logic             tc_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_c = ena && (cnt_q == LAST);
  assign cnt  = cnt_q;

  // clr wins over ena; a terminal count reloads 0 with no dead cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tc_c) begin
      cnt_d = '0;
    end else if (ena) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : timer32

// File: rtl/pulse_gen.sv
// Periodic trigger (pulse0) and delayed test pulse (pulse1) generator:
// two window comparators on the shared phase counter, registered outputs.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int unsigned TR_WIDTH   = DEF_TR_WIDTH,
  parameter int unsigned TP_DELAY   = DEF_TP_DELAY,
  parameter int unsigned TP_WIDTH   = DEF_TP_WIDTH
) (
  input  logic clk_in,
  input  logic rst_board,
  input  logic clr,
  input  logic ena,
  output logic pulse0,
  output logic pulse1
);

  localparam int unsigned CNT_W1 = CNT_W + 1;

  localparam logic [CNT_W-1:0] TR_LIM = CNT_W'(TR_WIDTH);
  localparam logic [CNT_W-1:0] TP_LO  = CNT_W'(TP_DELAY);
  // window end kept one bit wider so DELAY+WIDTH can never wrap
  localparam logic [CNT_W:0]   TP_HI  = CNT_W1'(TP_DELAY) + CNT_W1'(TP_WIDTH);

  if ((PERIOD_CYC < 2) || (TR_WIDTH == 0) || (TR_WIDTH > PERIOD_CYC) ||
      (TP_WIDTH == 0) ||
      ((CNT_W1'(TP_DELAY) + CNT_W1'(TP_WIDTH)) > CNT_W1'(PERIOD_CYC))) begin : g_bad_params
    $error("pulse_gen: illegal PERIOD_CYC/TR_WIDTH/TP_DELAY/TP_WIDTH combination");
  end

  logic [CNT_W-1:0] cnt;
  logic             tc_c;
  logic             pulse0_q;
  logic             pulse0_d;
  logic             pulse1_q;
  logic             pulse1_d;

  timer32 #(
    .PERIOD_CYC (PERIOD_CYC)
  ) u_timer (
    .clk  (clk_in),
    .rst  (rst_board),
    .clr  (clr),
    .ena  (ena),
    .cnt  (cnt),
    .tc_c (tc_c)
  );

  // outputs follow the pre-increment phase; idle or cleared forces both low
  always_comb begin
    pulse0_d = 1'b0;
    pulse1_d = 1'b0;
    if (!clr && ena) begin
      pulse0_d = (cnt < TR_LIM);
      pulse1_d = (cnt >= TP_LO) && ({1'b0, cnt} < TP_HI);
    end
  end

  always_ff @(posedge clk_in or negedge rst_board) begin
    if (!rst_board) begin
      pulse0_q <= 1'b0;
      pulse1_q <= 1'b0;
    end else begin
      pulse0_q <= pulse0_d;
      pulse1_q <= pulse1_d;
    end
  end

  assign pulse0 = pulse0_q;
  assign pulse1 = pulse1_q;

  a_wrap_to_zero : assert property (@(posedge clk_in) disable iff (!rst_board)
                                    tc_c |=> (cnt == '0));

endmodule : pulse_gen

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: three instances (small, full-duty, default params)
// compared against literal edge tables and a phase-count reference model.
module tb_pulse_gen;
  import pulse_gen_pkg::*;

  logic       clk_in    = 1'b0;
  logic       rst_board = 1'b0;
  logic       clr       = 1'b0;
  logic       ena       = 1'b0;
  logic [2:0] p0;
  logic [2:0] p1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_in = ~clk_in;

  pulse_gen #(.PERIOD_CYC(20), .TR_WIDTH(3), .TP_DELAY(5), .TP_WIDTH(2)) u_main (
    .clk_in(clk_in), .rst_board(rst_board), .clr(clr), .ena(ena),
    .pulse0(p0[0]), .pulse1(p1[0]));

  pulse_gen #(.PERIOD_CYC(20), .TR_WIDTH(20), .TP_DELAY(5), .TP_WIDTH(2)) u_full (
    .clk_in(clk_in), .rst_board(rst_board), .clr(clr), .ena(ena),
    .pulse0(p0[1]), .pulse1(p1[1]));

  pulse_gen u_def (
    .clk_in(clk_in), .rst_board(rst_board), .clr(clr), .ena(ena),
    .pulse0(p0[2]), .pulse1(p1[2]));

  // Reference model: count enabled edges since the last restart; the phase
  // is that count modulo the period, and each output is a window test on it.
  localparam int unsigned MP  [3] = '{20, 20, DEF_PERIOD_CYC};
  localparam int unsigned MTR [3] = '{3, 20, DEF_TR_WIDTH};
  localparam int unsigned MD  [3] = '{5, 5, DEF_TP_DELAY};
  localparam int unsigned MW  [3] = '{2, 2, DEF_TP_WIDTH};

  int unsigned m_run;
  logic [2:0]  m_p0;
  logic [2:0]  m_p1;

  function automatic logic win0(input int k, input int unsigned run);
    return (run % MP[k]) < MTR[k];
  endfunction

  function automatic logic win1(input int k, input int unsigned run);
    int unsigned ph;
    ph = run % MP[k];
    return (ph >= MD[k]) && (ph < MD[k] + MW[k]);
  endfunction

  always @(posedge clk_in or negedge rst_board) begin
    if (!rst_board) begin
      m_run <= 0;
      m_p0  <= '0;
      m_p1  <= '0;
    end else if (clr) begin
      m_run <= 0;
      m_p0  <= '0;
      m_p1  <= '0;
    end else if (ena) begin
      for (int k = 0; k < 3; k++) begin
        m_p0[k] <= win0(k, m_run);
        m_p1[k] <= win1(k, m_run);
      end
      m_run <= m_run + 1;
    end else begin
      m_p0 <= '0;
      m_p1 <= '0;
    end
  end

  typedef struct {
    logic ena;
    logic clr;
    logic p0;
    logic p1;
    logic full_p0;
  } vec_t;

  vec_t tbl [30];

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic chk(input string name, input int e, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s edge %0d: got %0b expected %0b (t=%0t)", name, e, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag, input int e);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_model_p0[%0d]", tag, k), e, p0[k], m_p0[k]);
      chk($sformatf("%s_model_p1[%0d]", tag, k), e, p1[k], m_p1[k]);
    end
  endtask

  task automatic do_reset();
    rst_board = 1'b0;
    clr       = 1'b0;
    ena       = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_board = 1'b1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 30; i++) begin
      ena = tbl[i].ena;
      clr = tbl[i].clr;
      tick();
      chk({tag, "_p0"}, i + 1, p0[0], tbl[i].p0);
      chk({tag, "_p1"}, i + 1, p1[0], tbl[i].p1);
      chk({tag, "_full_p0"}, i + 1, p0[1], tbl[i].full_p0);
    end
  endtask

  initial begin
    int e;
    int first_p0, last_p0, first_p1, last_p1;

    for (int i = 0; i < 30; i++) begin
      e = i + 1;
      tbl[i].ena     = 1'b1;
      tbl[i].clr     = 1'b0;
      tbl[i].p0      = (e >= 1 && e <= 3) || (e >= 21 && e <= 23);
      tbl[i].p1      = (e == 6) || (e == 7) || (e == 26) || (e == 27);
      tbl[i].full_p0 = 1'b1;
    end

    // outputs held low while in reset
    @(negedge clk_in);
    @(negedge clk_in);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_p0[%0d]", k), 0, p0[k], 1'b0);
      chk($sformatf("reset_p1[%0d]", k), 0, p1[k], 1'b0);
    end
    rst_board = 1'b1;

    // free-running pattern over the wrap
    run_table("run");

    // enable gap after edge 6 stretches the period by 4
    do_reset();
    for (int i = 1; i <= 31; i++) begin
      ena = !(i >= 7 && i <= 10);
      tick();
      chk("gap_p0", i, p0[0], (i <= 3) || (i >= 25 && i <= 27));
      chk("gap_p1", i, p1[0], (i == 6) || (i == 11) || (i == 30) || (i == 31));
    end

    // synchronous clear at edge 10
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      ena = 1'b1;
      clr = (i == 10);
      tick();
      chk("clr_p0", i, p0[0], (i <= 3) || (i >= 11 && i <= 13));
      chk("clr_p1", i, p1[0], (i == 6) || (i == 7) || (i == 16) || (i == 17));
    end
    clr = 1'b0;

    // async reset in the middle of pulse0, then a full restart
    do_reset();
    ena = 1'b1;
    tick();
    tick();
    chk("pre_rst_p0", 2, p0[0], 1'b1);
    #2;
    rst_board = 1'b0;
    #1;
    chk("async_rst_p0", 2, p0[0], 1'b0);
    chk("async_rst_full_p0", 2, p0[1], 1'b0);
    @(negedge clk_in);
    rst_board = 1'b1;
    run_table("restart");

    // default parameters: pulse0 on edges 1..111, pulse1 on 223..278
    do_reset();
    ena = 1'b1;
    first_p0 = -1; last_p0 = -1; first_p1 = -1; last_p1 = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (p0[2] === 1'b1) begin
        if (first_p0 < 0) first_p0 = i;
        last_p0 = i;
      end
      if (p1[2] === 1'b1) begin
        if (first_p1 < 0) first_p1 = i;
        last_p1 = i;
      end
      if (i % 50 == 0) chk_model("def", i);
    end
    chk_int("def_p0_rise", first_p0, 1);
    chk_int("def_p0_last", last_p0, 111);
    chk_int("def_p1_rise", first_p1, 223);
    chk_int("def_p1_last", last_p1, 278);
    chk_int("def_p1_offset", first_p1 - first_p0, 222);

    // randomized enable/clear/reset against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 249) == 0) begin
        #2;
        rst_board = 1'b0;
        #1;
        chk_model("rand_rst", i);
        @(negedge clk_in);
        rst_board = 1'b1;
      end
      tick();
      chk_model("rand", i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_pulse_gen

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SHALL have parameter PERIOD_CYC, default 111111, meaning the pulse repetition period in clk_in cycles (1.0 ms at 111.11 MHz).
REQ-002 SHALL have parameter TR_WIDTH, default 111, meaning the pulse0 high time in cycles (about 1 us).
REQ-003 SHALL have parameter TP_DELAY, default 222, meaning the pulse1 rise offset from the pulse0 rise, in cycles (about 2 us).
REQ-004 SHALL have parameter TP_WIDTH, default 56, meaning the pulse1 high time in cycles (about 0.5 us).
REQ-005 SHALL have port clk_in, input, 1 bit: system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_board, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port clr, input, 1 bit: synchronous restart of the period.
REQ-008 SHALL have port ena, input, 1 bit: run enable.
REQ-009 SHALL have port pulse0, output, 1 bit: trigger pulse (tr), registered.
REQ-010 SHALL have port pulse1, output, 1 bit: delayed test pulse (tp), registered.

Function
REQ-011 SHALL contain a 32-bit phase counter cnt, unsigned, with range 0..PERIOD_CYC-1.
REQ-012 At each rising edge, clr=1 SHALL set cnt<=0, pulse0<=0 and pulse1<=0. clr has priority over ena.
REQ-013 At each rising edge with clr=0 and ena=0, cnt SHALL hold, and pulse0 and pulse1 SHALL go to 0.
REQ-014 At each rising edge with clr=0 and ena=1:
- cnt <= 0 if cnt==PERIOD_CYC-1, else cnt <= cnt+1.
- pulse0 <= (cnt < TR_WIDTH).
- pulse1 <= (cnt >= TP_DELAY) && (cnt < TP_DELAY+TP_WIDTH).
REQ-015 Both outputs SHALL reflect the pre-increment cnt, giving one cycle of latency from cnt to output.
REQ-016 Wrap SHALL be seamless: the period is exactly PERIOD_CYC cycles, and there is no dead cycle at wrap.
REQ-017 After reset with ena held at 1:
- pulse0 is high on edges 1..TR_WIDTH.
- pulse1 is high on edges TP_DELAY+1..TP_DELAY+TP_WIDTH.
- Both patterns repeat every PERIOD_CYC edges.
REQ-018 Deasserting and then reasserting ena SHALL resume from the held cnt; the phase is not lost.
REQ-019 pulse1 MAY overlap pulse0 when TP_DELAY < TR_WIDTH; each output is evaluated independently.
REQ-020 Legal parameters SHALL satisfy all of the following; an elaboration-time check fails otherwise:
- PERIOD_CYC >= 2
- 1 <= TR_WIDTH <= PERIOD_CYC
- TP_WIDTH >= 1
- TP_DELAY+TP_WIDTH <= PERIOD_CYC
REQ-021 If TR_WIDTH == PERIOD_CYC, pulse0 SHALL stay high continuously while ena=1.
REQ-022 All comparisons SHALL be 32-bit unsigned, and the TP_DELAY+TP_WIDTH sum SHALL be computed in 33 bits with no overflow.

Reset
REQ-023 rst_board low SHALL asynchronously force cnt=0, pulse0=0 and pulse1=0.
REQ-024 Reset release SHALL take effect at the next rising edge, with no glitch on the outputs.
REQ-025 Reset asserted mid-pulse SHALL drop both outputs immediately and restart the period from cnt=0.

Structure
REQ-026 A shared package SHALL hold:
- CLK_HZ = 111_111_111
- the default values of PERIOD_CYC, TR_WIDTH, TP_DELAY and TP_WIDTH
- the counter width constant CNT_W = 32
REQ-027 The phase counter SHALL be one sub-module, timer32, with ports clk, rst, clr, ena, the 32-bit count, and a terminal-count strobe.
REQ-028 pulse_gen SHALL instantiate timer32 and implement only the two comparators and the output registers.

Verification
The bench uses PERIOD_CYC=20, TR_WIDTH=3, TP_DELAY=5, TP_WIDTH=2 unless stated otherwise.
REQ-029 Reset, then ena=1 and clr=0 -> pulse0 high on edges 1-3 and 21-23; pulse1 high on edges 6-7 and 26-27; both low elsewhere.
REQ-030 ena=0 for 4 cycles starting at edge 6 -> both outputs low during the gap; after ena returns, pulse1 resumes high for its remaining cycle and the period is stretched by 4.
REQ-031 clr=1 at edge 10 -> both outputs low; pulse0 rises again 1 edge after clr falls.
REQ-032 rst_board low mid-pulse0 -> pulse0 drops asynchronously; after release, the full sequence restarts from edge 1.
REQ-033 TR_WIDTH=20 -> pulse0 is constantly high after edge 1 across the wrap.
REQ-034 Default parameters over 3 periods -> pulse0 rise-to-rise spacing is exactly 111111 cycles and pulse1 rise is exactly 222 cycles after each pulse0 rise.
